// File: rtl/write_channel_burst_native_pkg.sv
`default_nettype none
// ============================================================================
// Module      : write_channel_burst_native_pkg
// Description : Shared types for the cache write channel: write-policy
//               encodings and the channel state type.
// Revision    : 1.0 - initial release
// ============================================================================

`ifndef WRITE_THROUGH
`define WRITE_THROUGH 0
`endif
`ifndef WRITE_BACK
`define WRITE_BACK 1
`endif

package write_channel_burst_native_pkg;

    // Write-policy encodings, mirrored from the shared cache macros
    localparam int C_WRITE_THROUGH = `WRITE_THROUGH;
    localparam int C_WRITE_BACK    = `WRITE_BACK;

    // Channel state: idle, or a back-end request outstanding
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_WRITE = 1'b1
    } wr_state_e;

endpackage

`default_nettype wire

// File: rtl/write_merge_buf.sv
`default_nettype none
// ============================================================================
// Module      : write_merge_buf
// Description : One-entry staging register that sits behind the active
//               back-end beat. Requests to the same back-end word merge into
//               the entry (strobes OR'd, strobed bytes overwritten).
// Revision    : 1.0 - initial release
// ============================================================================

module write_merge_buf #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 128
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_push,
    input  logic                  i_pop,
    input  logic [ADDR_W-1:0]     i_addr,
    input  logic [DATA_W-1:0]     i_wdata,
    input  logic [DATA_W/8-1:0]   i_wstrb,
    output logic                  o_valid,
    output logic                  o_hit,
    output logic [ADDR_W-1:0]     o_addr,
    output logic [DATA_W-1:0]     o_wdata,
    output logic [DATA_W/8-1:0]   o_wstrb
);

    localparam int NBYTES = DATA_W / 8;

    logic                 r_valid;
    logic [ADDR_W-1:0]    r_addr;
    logic [DATA_W-1:0]    r_wdata;
    logic [NBYTES-1:0]    r_wstrb;
    logic [DATA_W-1:0]    w_mask;
    logic [DATA_W-1:0]    w_merged;

    // Expand the incoming byte strobes to a bit mask
    for (genvar b = 0; b < NBYTES; b++) begin : g_mask
        assign w_mask[b*8 +: 8] = {8{i_wstrb[b]}};
    end

    assign w_merged = (r_wdata & ~w_mask) | (i_wdata & w_mask);
    assign o_hit    = r_valid & (r_addr == i_addr);
    assign o_valid  = r_valid;
    assign o_addr   = r_addr;
    assign o_wdata  = r_wdata;
    assign o_wstrb  = r_wstrb;

    // Entry load / merge; a pop hands the entry off, so a push in the same
    // cycle starts a fresh entry rather than merging into the departing one.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_wstrb <= '0;
        end else if (i_pop) begin
            r_valid <= i_push;
            r_wstrb <= i_push ? i_wstrb : '0;
            if (i_push) begin
                r_addr  <= i_addr;
                r_wdata <= i_wdata;
            end
        end else if (i_push) begin
            r_valid <= 1'b1;
            if (r_valid) begin
                r_wstrb <= r_wstrb | i_wstrb;
                r_wdata <= w_merged;
            end else begin
                r_addr  <= i_addr;
                r_wdata <= i_wdata;
                r_wstrb <= i_wstrb;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/write_channel_burst_native.sv
`default_nettype none
// ============================================================================
// Module      : write_channel_burst_native
// Description : Cache write channel onto the native memory interface.
//               Write-through issues single BE-aligned beats; write-back
//               streams a whole line as 2^LINE2MEM_W beats. mem_* outputs
//               are registered and held while the back end stalls.
//               Optional macro CACHE_WR_MERGE_EN adds a one-entry merging
//               staging register (write-through only).
// Revision    : 1.0 - initial release
// ============================================================================

`ifndef WRITE_THROUGH
`define WRITE_THROUGH 0
`endif
`ifndef WRITE_BACK
`define WRITE_BACK 1
`endif

module write_channel_burst_native
    import write_channel_burst_native_pkg::*;
#(
    parameter int FE_ADDR_W  = 32,
    parameter int FE_DATA_W  = 32,
    parameter int BE_ADDR_W  = FE_ADDR_W,
    parameter int BE_DATA_W  = FE_DATA_W,
    parameter int WRITE_POL  = `WRITE_THROUGH,
    parameter int WORD_OFF_W = 3
) (
    input  logic                                                         clk,
    input  logic                                                         reset,
    input  logic                                                         valid,
    input  logic [FE_ADDR_W-$clog2(FE_DATA_W/8)-WRITE_POL*WORD_OFF_W-1:0] addr,
    input  logic [FE_DATA_W/8-1:0]                                       wstrb,
    input  logic [FE_DATA_W*(1<<(WORD_OFF_W*WRITE_POL))-1:0]             wdata,
    output logic                                                         ready,
    output logic                                                         busy,
    output logic                                                         mem_valid,
    output logic [BE_ADDR_W-1:0]                                         mem_addr,
    output logic [BE_DATA_W-1:0]                                         mem_wdata,
    output logic [BE_DATA_W/8-1:0]                                       mem_wstrb,
    input  logic                                                         mem_ready
);

    localparam int FE_NBYTES  = FE_DATA_W / 8;
    localparam int FE_BYTE_W  = $clog2(FE_NBYTES);
    localparam int BE_NBYTES  = BE_DATA_W / 8;
    localparam int BE_BYTE_W  = $clog2(BE_NBYTES);
    localparam int RATIO_W    = BE_BYTE_W - FE_BYTE_W;
    localparam int RATIO      = 1 << RATIO_W;
    localparam int LINE2MEM_W = WORD_OFF_W - RATIO_W;
    localparam int LINE_W     = FE_DATA_W * (1 << (WORD_OFF_W * WRITE_POL));
    localparam int BEAT_W     = (WRITE_POL == C_WRITE_BACK) ? LINE2MEM_W : 0;
    localparam int CNT_W      = (BEAT_W > 0) ? BEAT_W : 1;

    wr_state_e              r_state;
    logic [CNT_W-1:0]       r_beat;

    logic                   w_idle;
    logic                   w_last_beat;
    logic                   w_ack;
    logic                   w_done;
    logic                   w_accept;
    logic                   w_load_req;
    logic                   w_load_stg;
    logic [BE_ADDR_W-1:0]   w_req_addr;
    logic [BE_DATA_W-1:0]   w_req_wdata;
    logic [BE_NBYTES-1:0]   w_req_wstrb;
    logic [BE_ADDR_W-1:0]   w_nxt_addr;
    logic [BE_DATA_W-1:0]   w_nxt_wdata;
    logic                   w_stg_valid;
    logic                   w_stg_hit;
    logic [BE_ADDR_W-1:0]   w_stg_addr;
    logic [BE_DATA_W-1:0]   w_stg_wdata;
    logic [BE_NBYTES-1:0]   w_stg_wstrb;

    assign w_idle      = (r_state == ST_IDLE);
    assign w_last_beat = (BEAT_W == 0) ? 1'b1 : &r_beat;
    assign w_ack       = mem_valid & mem_ready;
    assign w_done      = w_ack & w_last_beat;
    assign w_accept    = valid & ready;
    // A new request goes straight to the active beat only when nothing is
    // staged ahead of it; a staged entry always takes the slot first.
    assign w_load_req  = w_accept & (w_idle | w_done) & ~w_stg_valid;
    assign w_load_stg  = w_done & w_stg_valid;
    assign busy        = ~w_idle | w_stg_valid;

    if (WRITE_POL == C_WRITE_THROUGH) begin : g_wt
        localparam int ALIGN_W = (RATIO_W > 0) ? RATIO_W : 1;
        logic [ALIGN_W-1:0]   w_align;
        logic [FE_ADDR_W-1:0] w_byte_addr;

        // Word position of the FE word inside the BE word
        assign w_align     = (RATIO_W > 0) ? addr[ALIGN_W-1:0] : '0;
        assign w_byte_addr = FE_ADDR_W'(addr) << FE_BYTE_W;
        assign w_req_addr  = BE_ADDR_W'(w_byte_addr & ~FE_ADDR_W'(BE_NBYTES - 1));
        assign w_req_wdata = {RATIO{wdata[FE_DATA_W-1:0]}};
        assign w_req_wstrb = BE_NBYTES'(wstrb) << (FE_NBYTES * int'(w_align));
        // Single beat: there is never a following beat to advance to
        assign w_nxt_addr  = mem_addr;
        assign w_nxt_wdata = mem_wdata;
    end else begin : g_wb
        logic [LINE_W-1:0]    r_rest;
        logic [FE_ADDR_W-1:0] w_byte_addr;
        logic                 w_unused_wstrb;

        assign w_byte_addr    = FE_ADDR_W'(addr) << (WORD_OFF_W + FE_BYTE_W);
        assign w_req_addr     = BE_ADDR_W'(w_byte_addr);
        assign w_req_wdata    = wdata[BE_DATA_W-1:0];
        assign w_req_wstrb    = '1;
        // The line base is aligned, so beat offsets never carry into it
        assign w_nxt_addr     = mem_addr + BE_ADDR_W'(BE_NBYTES);
        assign w_nxt_wdata    = r_rest[BE_DATA_W-1:0];
        assign w_unused_wstrb = ^wstrb;

        // Beats not yet issued, shifted down by one beat per acknowledge
        always_ff @(posedge clk) begin
            if (reset) begin
                r_rest <= '0;
            end else if (w_load_req) begin
                r_rest <= wdata >> BE_DATA_W;
            end else if (w_ack && !w_last_beat) begin
                r_rest <= r_rest >> BE_DATA_W;
            end
        end
    end

`ifdef CACHE_WR_MERGE_EN
    if (WRITE_POL == C_WRITE_THROUGH) begin : g_merge
        logic w_to_stg;

        assign w_to_stg = w_accept & ~w_load_req;
        // Staging frees up on the acknowledge, so any request fits then
        assign ready    = ~w_stg_valid | w_stg_hit | w_done;

        write_merge_buf #(
            .ADDR_W (BE_ADDR_W),
            .DATA_W (BE_DATA_W)
        ) u_merge (
            .clk     (clk),
            .rst     (reset),
            .i_push  (w_to_stg),
            .i_pop   (w_load_stg),
            .i_addr  (w_req_addr),
            .i_wdata (w_req_wdata),
            .i_wstrb (w_req_wstrb),
            .o_valid (w_stg_valid),
            .o_hit   (w_stg_hit),
            .o_addr  (w_stg_addr),
            .o_wdata (w_stg_wdata),
            .o_wstrb (w_stg_wstrb)
        );
    end else begin : g_no_merge
        assign ready       = w_idle | w_done;
        assign w_stg_valid = 1'b0;
        assign w_stg_hit   = 1'b0;
        assign w_stg_addr  = '0;
        assign w_stg_wdata = '0;
        assign w_stg_wstrb = '0;
    end
`else
    assign ready       = w_idle | w_done;
    assign w_stg_valid = 1'b0;
    assign w_stg_hit   = 1'b0;
    assign w_stg_addr  = '0;
    assign w_stg_wdata = '0;
    assign w_stg_wstrb = '0;
`endif

    // Channel FSM: request capture, beat sequencing and registered mem_* outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_beat    <= '0;
            mem_valid <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
        end else if (w_load_stg) begin
            r_state   <= ST_WRITE;
            r_beat    <= '0;
            mem_valid <= 1'b1;
            mem_addr  <= w_stg_addr;
            mem_wdata <= w_stg_wdata;
            mem_wstrb <= w_stg_wstrb;
        end else if (w_load_req) begin
            r_state   <= ST_WRITE;
            r_beat    <= '0;
            mem_valid <= 1'b1;
            mem_addr  <= w_req_addr;
            mem_wdata <= w_req_wdata;
            mem_wstrb <= w_req_wstrb;
        end else if (w_done) begin
            r_state   <= ST_IDLE;
            r_beat    <= '0;
            mem_valid <= 1'b0;
        end else if (w_ack) begin
            r_beat    <= r_beat + CNT_W'(1);
            mem_addr  <= w_nxt_addr;
            mem_wdata <= w_nxt_wdata;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_write_channel_burst_native.sv
`default_nettype none
// ============================================================================
// Module      : tb_write_channel_burst_native
// Description : Directed bench for write_channel_burst_native: a
//               write-through instance (FE32/BE128) and a write-back
//               instance (FE32/BE64, 8-word lines).
// Revision    : 1.0 - initial release
// ============================================================================

`ifndef WRITE_THROUGH
`define WRITE_THROUGH 0
`endif
`ifndef WRITE_BACK
`define WRITE_BACK 1
`endif

module tb_write_channel_burst_native;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Write-through instance signals
    logic          wt_valid = 1'b0;
    logic [29:0]   wt_addr  = '0;
    logic [3:0]    wt_wstrb = '0;
    logic [31:0]   wt_wdata = '0;
    logic          wt_ready, wt_busy, wt_mem_valid;
    logic [31:0]   wt_mem_addr;
    logic [127:0]  wt_mem_wdata;
    logic [15:0]   wt_mem_wstrb;
    logic          wt_mem_ready = 1'b0;

    // Write-back instance signals
    logic          wb_valid = 1'b0;
    logic [26:0]   wb_addr  = '0;
    logic [3:0]    wb_wstrb = '0;
    logic [255:0]  wb_wdata = '0;
    logic          wb_ready, wb_busy, wb_mem_valid;
    logic [31:0]   wb_mem_addr;
    logic [63:0]   wb_mem_wdata;
    logic [7:0]    wb_mem_wstrb;
    logic          wb_mem_ready = 1'b0;

    write_channel_burst_native #(
        .FE_ADDR_W(32), .FE_DATA_W(32), .BE_ADDR_W(32), .BE_DATA_W(128),
        .WRITE_POL(`WRITE_THROUGH), .WORD_OFF_W(3)
    ) u_wt (
        .clk(clk), .reset(reset), .valid(wt_valid), .addr(wt_addr),
        .wstrb(wt_wstrb), .wdata(wt_wdata), .ready(wt_ready), .busy(wt_busy),
        .mem_valid(wt_mem_valid), .mem_addr(wt_mem_addr),
        .mem_wdata(wt_mem_wdata), .mem_wstrb(wt_mem_wstrb),
        .mem_ready(wt_mem_ready)
    );

    write_channel_burst_native #(
        .FE_ADDR_W(32), .FE_DATA_W(32), .BE_ADDR_W(32), .BE_DATA_W(64),
        .WRITE_POL(`WRITE_BACK), .WORD_OFF_W(3)
    ) u_wb (
        .clk(clk), .reset(reset), .valid(wb_valid), .addr(wb_addr),
        .wstrb(wb_wstrb), .wdata(wb_wdata), .ready(wb_ready), .busy(wb_busy),
        .mem_valid(wb_mem_valid), .mem_addr(wb_mem_addr),
        .mem_wdata(wb_mem_wdata), .mem_wstrb(wb_mem_wstrb),
        .mem_ready(wb_mem_ready)
    );

    typedef struct {
        logic         valid;
        logic [29:0]  addr;
        logic [3:0]   wstrb;
        logic [31:0]  wdata;
        logic         mem_ready;
        logic         chk_data;
        logic         e_ready;
        logic         e_mvalid;
        logic         e_busy;
        logic [31:0]  e_addr;
        logic [15:0]  e_wstrb;
        logic [127:0] e_wdata;
    } vec_t;

    function automatic vec_t mk(input logic v, input logic [29:0] a,
                                input logic [3:0] s, input logic [31:0] d,
                                input logic mr, input logic chk,
                                input logic er, input logic emv, input logic eb,
                                input logic [31:0] ea, input logic [15:0] es,
                                input logic [127:0] ed);
        vec_t r;
        r.valid = v; r.addr = a; r.wstrb = s; r.wdata = d; r.mem_ready = mr;
        r.chk_data = chk; r.e_ready = er; r.e_mvalid = emv; r.e_busy = eb;
        r.e_addr = ea; r.e_wstrb = es; r.e_wdata = ed;
        return r;
    endfunction

    task automatic check(input string name, input logic [255:0] act,
                         input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One write-through cycle: drive, settle, compare, advance to next edge
    task automatic wt_step(input string name, input vec_t t);
        wt_valid = t.valid; wt_addr = t.addr; wt_wstrb = t.wstrb;
        wt_wdata = t.wdata; wt_mem_ready = t.mem_ready;
        #1;
        check({name, "_ctl"}, {wt_ready, wt_mem_valid, wt_busy},
              {t.e_ready, t.e_mvalid, t.e_busy});
        if (t.chk_data)
            check({name, "_dat"}, {wt_mem_addr, wt_mem_wstrb, wt_mem_wdata},
                  {t.e_addr, t.e_wstrb, t.e_wdata});
        @(posedge clk); #1;
    endtask

    // One write-back cycle; busy tracks mem_valid throughout these sequences
    task automatic wb_step(input string name, input logic v, input logic mr,
                           input logic e_ready, input logic e_mv,
                           input logic [31:0] e_addr, input logic [63:0] e_data);
        wb_valid = v; wb_mem_ready = mr;
        #1;
        check({name, "_ctl"}, {wb_ready, wb_mem_valid, wb_busy},
              {e_ready, e_mv, e_mv});
        if (e_mv)
            check({name, "_dat"}, {wb_mem_addr, wb_mem_wstrb, wb_mem_wdata},
                  {e_addr, 8'hFF, e_data});
        @(posedge clk); #1;
    endtask

    vec_t vt[12];
    logic [255:0] line1;
    logic [255:0] line2;

    initial begin
        vt[0]  = mk(1, 30'h5, 4'hF, 32'hDEADBEEF, 0, 0, 1, 0, 0, 0, 0, 0);
        vt[1]  = mk(0, 0, 0, 0, 0, 1, 0, 1, 1, 32'h10, 16'h00F0, {4{32'hDEADBEEF}});
        vt[2]  = mk(1, 30'h9, 4'hF, 32'h12345678, 0, 1, 0, 1, 1, 32'h10, 16'h00F0, {4{32'hDEADBEEF}});
        vt[3]  = mk(0, 0, 0, 0, 1, 1, 1, 1, 1, 32'h10, 16'h00F0, {4{32'hDEADBEEF}});
        vt[4]  = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        vt[5]  = mk(1, 30'h2, 4'h3, 32'h11223344, 1, 0, 1, 0, 0, 0, 0, 0);
        vt[6]  = mk(1, 30'h7, 4'hC, 32'hAABBCCDD, 1, 1, 1, 1, 1, 32'h0, 16'h0300, {4{32'h11223344}});
        vt[7]  = mk(0, 0, 0, 0, 1, 1, 1, 1, 1, 32'h10, 16'hC000, {4{32'hAABBCCDD}});
        vt[8]  = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        vt[9]  = mk(1, 30'h3FFFFFFF, 4'h5, 32'h0F0F0F0F, 0, 0, 1, 0, 0, 0, 0, 0);
        vt[10] = mk(0, 0, 0, 0, 0, 1, 0, 1, 1, 32'hFFFFFFF0, 16'h5000, {4{32'h0F0F0F0F}});
        vt[11] = mk(0, 0, 0, 0, 1, 1, 1, 1, 1, 32'hFFFFFFF0, 16'h5000, {4{32'h0F0F0F0F}});

        line1 = {32'h77777777, 32'h66666666, 32'h55555555, 32'h44444444,
                 32'h33333333, 32'h22222222, 32'h11111111, 32'h00000000};
        line2 = {32'hA7A7A7A7, 32'hA6A6A6A6, 32'hA5A5A5A5, 32'hA4A4A4A4,
                 32'hA3A3A3A3, 32'hA2A2A2A2, 32'hA1A1A1A1, 32'hA0A0A0A0};

        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state of both instances
        wt_step("wt_reset", mk(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0));
        #0;
        check("wb_reset", {wb_ready, wb_busy, wb_mem_valid, wb_mem_addr, wb_mem_wstrb, wb_mem_wdata},
              {1'b1, 1'b0, 1'b0, 32'h0, 8'h0, 64'h0});

`ifdef CACHE_WR_MERGE_EN
        // Merge: active beat stalled, two same-word requests merge in staging,
        // a different-word request waits for the acknowledge.
        wt_step("mg_a",     mk(1, 30'h8, 4'hF, 32'hCAFEF00D, 0, 0, 1, 0, 0, 0, 0, 0));
        wt_step("mg_b",     mk(1, 30'h5, 4'h3, 32'h00001234, 0, 1, 1, 1, 1, 32'h20, 16'h000F, {4{32'hCAFEF00D}}));
        wt_step("mg_c",     mk(1, 30'h5, 4'hC, 32'h56780000, 0, 1, 1, 1, 1, 32'h20, 16'h000F, {4{32'hCAFEF00D}}));
        wt_step("mg_d_blk", mk(1, 30'h9, 4'hF, 32'h9ABCDEF0, 0, 1, 0, 1, 1, 32'h20, 16'h000F, {4{32'hCAFEF00D}}));
        wt_step("mg_d_acc", mk(1, 30'h9, 4'hF, 32'h9ABCDEF0, 1, 1, 1, 1, 1, 32'h20, 16'h000F, {4{32'hCAFEF00D}}));
        wt_step("mg_merged", mk(0, 0, 0, 0, 1, 1, 1, 1, 1, 32'h10, 16'h00F0,
                                {32'h00001234, 32'h00001234, 32'h56781234, 32'h00001234}));
        wt_step("mg_d_beat", mk(0, 0, 0, 0, 1, 1, 1, 1, 1, 32'h20, 16'h00F0, {4{32'h9ABCDEF0}}));
        wt_step("mg_idle",  mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
`else
        for (int i = 0; i < 12; i++)
            wt_step($sformatf("wt_vec%0d", i), vt[i]);
`endif
        wt_valid = 1'b0; wt_mem_ready = 1'b0;

        // Write-back line with a three-cycle stall on beat 1
        wb_addr = 27'h123; wb_wdata = line1;
        wb_step("wb_acc",    1, 0, 1, 0, 32'h0,    64'h0);
        wb_step("wb_b0",     0, 1, 0, 1, 32'h2460, {32'h11111111, 32'h00000000});
        wb_step("wb_b1_st0", 0, 0, 0, 1, 32'h2468, {32'h33333333, 32'h22222222});
        wb_step("wb_b1_st1", 0, 0, 0, 1, 32'h2468, {32'h33333333, 32'h22222222});
        wb_step("wb_b1_st2", 0, 0, 0, 1, 32'h2468, {32'h33333333, 32'h22222222});
        wb_step("wb_b1_ack", 0, 1, 0, 1, 32'h2468, {32'h33333333, 32'h22222222});
        wb_step("wb_b2",     0, 1, 0, 1, 32'h2470, {32'h55555555, 32'h44444444});
        wb_step("wb_b3",     0, 1, 1, 1, 32'h2478, {32'h77777777, 32'h66666666});
        wb_step("wb_idle",   0, 0, 1, 0, 32'h0,    64'h0);

        // Reset during beat 2, then the same line restarts from beat 0
        wb_addr = 27'h055; wb_wdata = line2;
        wb_step("wbr_acc", 1, 1, 1, 0, 32'h0,   64'h0);
        wb_step("wbr_b0",  0, 1, 0, 1, 32'hAA0, {32'hA1A1A1A1, 32'hA0A0A0A0});
        wb_step("wbr_b1",  0, 1, 0, 1, 32'hAA8, {32'hA3A3A3A3, 32'hA2A2A2A2});
        reset = 1'b1;
        wb_step("wbr_b2",  0, 0, 0, 1, 32'hAB0, {32'hA5A5A5A5, 32'hA4A4A4A4});
        reset = 1'b0;
        check("wbr_rst_vals", {wb_ready, wb_busy, wb_mem_valid, wb_mem_addr, wb_mem_wstrb, wb_mem_wdata},
              {1'b1, 1'b0, 1'b0, 32'h0, 8'h0, 64'h0});
        wb_step("wbr_re_acc", 1, 0, 1, 0, 32'h0,   64'h0);
        wb_step("wbr_re_b0",  0, 1, 0, 1, 32'hAA0, {32'hA1A1A1A1, 32'hA0A0A0A0});
        wb_step("wbr_re_b1",  0, 1, 0, 1, 32'hAA8, {32'hA3A3A3A3, 32'hA2A2A2A2});
        wb_step("wbr_re_b2",  0, 1, 0, 1, 32'hAB0, {32'hA5A5A5A5, 32'hA4A4A4A4});
        wb_step("wbr_re_b3",  0, 1, 1, 1, 32'hAB8, {32'hA7A7A7A7, 32'hA6A6A6A6});
        wb_step("wbr_idle",   0, 0, 1, 0, 32'h0,   64'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/write_channel_burst_native.md
Name: write_channel_burst_native

Overview:
Next-generation cache write channel on the native memory interface. It sits between the cache write-policy logic and the back-end memory port.
- Write-through: single-word writes.
- Write-back: multi-beat line evictions.
- Any power-of-two BE/FE width ratio.
- Proper valid/ready semantics: mem_* held stable until acknowledged; zero-bubble back-to-back requests.

Parameters:
FE_ADDR_W, 32, front-end byte address width
FE_DATA_W, 32, front-end word width (bits)
BE_ADDR_W, FE_ADDR_W, back-end byte address width
BE_DATA_W, FE_DATA_W, back-end word width; BE_DATA_W >= FE_DATA_W, ratio power of two
WRITE_POL, `WRITE_THROUGH, `WRITE_THROUGH (0) or `WRITE_BACK (1)
WORD_OFF_W, 3, log2(FE words per line); used only for write-back
Derived locals (not overridable):
- FE_NBYTES, FE_BYTE_W, BE_NBYTES, BE_BYTE_W
- LINE2MEM_W = WORD_OFF_W - log2(BE_DATA_W/FE_DATA_W), must be >= 0
- LINE_W = FE_DATA_W * 2^(WORD_OFF_W*WRITE_POL)

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  synchronous, active-high reset
valid  in  1  front-end write request
addr  in  FE_ADDR_W-FE_BYTE_W-WRITE_POL*WORD_OFF_W  word address (WT) or line address (WB)
wstrb  in  FE_NBYTES  byte enables; WT only, ignored in WB
wdata  in  LINE_W  word (WT) or whole line (WB)
ready  out  1  request accepted this cycle (valid & ready)
busy  out  1  transfer in flight or request staged
mem_valid  out  1  back-end request, registered
mem_addr  out  BE_ADDR_W  back-end byte address, BE-aligned, registered
mem_wdata  out  BE_DATA_W  back-end write data, registered
mem_wstrb  out  BE_NBYTES  back-end byte enables, registered
mem_ready  in  1  back-end acknowledge of the current beat

Behaviour:
Reset values:
- mem_valid=0, mem_addr=0, mem_wdata=0, mem_wstrb=0.
- state=IDLE, beat counter=0, busy=0, ready=1.

FSM:
- IDLE -> WRITE on valid: request captured; mem_valid=1 the next cycle.
- WRITE holds while !(mem_valid & mem_ready & last_beat).
- On the final acknowledge: if valid is also present, capture it and stay in WRITE with mem_valid still 1 (zero bubble); otherwise go to IDLE with mem_valid=0.

ready (combinational) = (state==IDLE) | (mem_ready & mem_valid & last_beat).

Stability: mem_addr, mem_wdata and mem_wstrb must not change while mem_valid=1 and mem_ready=0.

Write-through (single beat, last_beat=1):
- mem_addr = {addr upper bits, BE_BYTE_W zeros}.
- mem_wdata = FE word replicated BE_DATA_W/FE_DATA_W times.
- mem_wstrb = wstrb << (word_align*FE_NBYTES), where word_align = addr low BE_BYTE_W-FE_BYTE_W bits.
- Latency: acceptance to first mem_valid = 1 cycle.

Write-back (2^LINE2MEM_W beats; beat counter LINE2MEM_W bits, 0 when LINE2MEM_W=0):
- Beat k: mem_addr = {line addr, k, BE_BYTE_W zeros}; mem_wdata = line[k*BE_DATA_W +: BE_DATA_W]; mem_wstrb all ones.
- Counter increments only on mem_valid & mem_ready; last_beat = counter all-ones.
- Wraps to 0 on the last acknowledge.

Stalls: mem_ready low for any number of cycles freezes the counter and all mem_* outputs.

Reset mid-transfer: next cycle mem_valid=0, counter=0, state IDLE; the in-flight request is dropped, with no partial-completion indication.

valid while not ready: ignored. The requester must hold it.

Optional Feature:
Macro CACHE_WR_MERGE_EN (effective only when WRITE_POL==`WRITE_THROUGH).

With the macro defined:
- One-entry staging register behind the active beat.
- ready=1 while staging is empty, or when staging holds the same BE word address as the incoming request.
- Same-address requests merge into staging: strobes OR'd; data bytes overwritten where the new wstrb is set.
- Staging moves to the active beat on the acknowledge cycle; it cannot be merged that cycle, so a same-cycle request becomes a new staging entry.
- busy covers staging.

Without the macro: no staging register; ready exactly as in Behaviour.

Write-back is unchanged in both builds.

Decomposition:
- iob-cache.vh holds `WRITE_THROUGH/`WRITE_BACK and any shared width macros; no new package contents.
- Natural sub-module: write_merge_buf (staging register, address compare, strobe/data merge), instantiated only under CACHE_WR_MERGE_EN.

Test Plan:
- WT FE32/BE128: valid, addr word 0x5, wstrb 0xF, wdata 0xDEADBEEF -> next cycle mem_valid=1, mem_addr=0x10, mem_wstrb=0x00F0, wdata replicated x4; ready=1 on mem_ready.
- WB FE32/BE64/WORD_OFF_W=3: one line, mem_ready low 3 cycles on beat 1 -> 4 beats at offsets 0x0/0x8/0x10/0x18, beat 1 outputs frozen during stall, ready only on the 4th acknowledge.
- Back-to-back WT: two requests with mem_ready tied 1 -> mem_valid continuously 1 for 2 cycles, second beat's address/data correct, no idle cycle.
- Reset asserted on WB beat 2 -> mem_valid=0 next cycle; new request restarts at beat 0.
- CACHE_WR_MERGE_EN: mem_ready held 0, two requests to the same BE word with wstrb 0x3 then 0xC -> both accepted; second beat issued with wstrb 0xF and merged data.
- Different-address request while staging is full -> ready=0 until the acknowledge.
